// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan_6 display driver: digit count, active-high
// segment patterns ordered {g,f,e,d,c,b,a}, and segment bit positions.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int IDX_W      = 3;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        digit_onehot = NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD-to-segment decoder; non-decimal codes show a dash and the
// blank input forces every segment off. Output is active-high {g..a}.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = SEG_OFF;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    pattern_o = SEG_0;
                4'd1:    pattern_o = SEG_1;
                4'd2:    pattern_o = SEG_2;
                4'd3:    pattern_o = SEG_3;
                4'd4:    pattern_o = SEG_4;
                4'd5:    pattern_o = SEG_5;
                4'd6:    pattern_o = SEG_6;
                4'd7:    pattern_o = SEG_7;
                4'd8:    pattern_o = SEG_8;
                4'd9:    pattern_o = SEG_9;
                default: pattern_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_6.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot and
// leading-zero blanking. Define SEG_DP_EN to add the dp_pos decimal-point port.
module seg_scan_6
    import seg_pkg::*;
#(
    parameter int CNT_MAX     = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] thou,
    input  logic [3:0] ten_thou,
    input  logic [3:0] hun_thou,
`ifdef SEG_DP_EN
    input  logic [2:0] dp_pos,
`endif
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int                    CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_INV  = {NUM_DIGITS{SEL_ACT_LOW}};
    localparam logic [7:0]            SEG_INV  = {8{SEG_ACT_LOW}};

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]       snap_q, snap_d;
    logic [NUM_DIGITS-1:0]            sel_q, sel_d;
    logic [7:0]                       seg_q, seg_d;
`ifdef SEG_DP_EN
    logic [IDX_W-1:0]                 dp_q, dp_d;
`endif

    logic                             tick;
    logic                             wrap;
    logic [NUM_DIGITS-1:0][3:0]       digits_in;
    logic [NUM_DIGITS-1:0]            nz;
    logic [NUM_DIGITS-1:0]            blank_mask;
    logic [3:0]                       cur_digit;
    logic                             cur_blank;
    logic [6:0]                       cur_pattern;
    logic                             dp_on;
    logic [7:0]                       seg_raw;

    assign digits_in = {hun_thou, ten_thou, thou, hun, ten, unit};

    // Digit i is blanked only when it and every digit above it are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
        assign nz[gi] = |snap_q[gi];
    end

    assign blank_mask[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
`ifdef SEG_DP_EN
        assign blank_mask[gi] = ~|nz[NUM_DIGITS-1:gi] && (dp_q < IDX_W'(gi));
`else
        assign blank_mask[gi] = ~|nz[NUM_DIGITS-1:gi];
`endif
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = snap_q[i];
                cur_blank = blank_mask[i];
            end
        end
    end

`ifdef SEG_DP_EN
    assign dp_on = (idx_q == dp_q);
`else
    assign dp_on = 1'b0;
`endif

    seg_decoder u_decoder (
        .bcd_i     (cur_digit),
        .blank_i   (cur_blank),
        .pattern_o (cur_pattern)
    );

    always_comb begin
        seg_raw                       = 8'h00;
        seg_raw[SEG_DP_BIT]           = dp_on;
        seg_raw[SEG_G_BIT:SEG_A_BIT]  = cur_pattern;
    end

    // Output registers load on tick from the slot that is ending its count, so
    // a slot's digit is visible for the CNT_MAX clocks that follow its tick and
    // the frame boundary (snapshot reload) lines up with digit 0 of each frame.
    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        wrap   = tick && (idx_q == IDX_LAST);
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        snap_d = snap_q;
        sel_d  = sel_q;
        seg_d  = seg_q;
`ifdef SEG_DP_EN
        dp_d   = dp_q;
`endif
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
            sel_d = digit_onehot(idx_q) ^ SEL_INV;
            seg_d = seg_raw ^ SEG_INV;
        end
        if (wrap) begin
            snap_d = digits_in;
`ifdef SEG_DP_EN
            dp_d   = dp_pos;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            sel_q  <= SEL_INV;
            seg_q  <= SEG_INV;
`ifdef SEG_DP_EN
            dp_q   <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
`ifdef SEG_DP_EN
            dp_q   <= dp_d;
`endif
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_6.sv
// Self-checking bench for seg_scan_6 (CNT_MAX=4, default polarities): a
// time-based display model plus literal spot checks of directed scenarios.
`timescale 1ns/1ps
module tb_seg_scan_6;

    localparam int CNT_MAX = 4;
    localparam int ND      = 6;
    localparam int FRAME   = CNT_MAX * ND;

    localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                        7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                        7'h40, 7'h40, 7'h40, 7'h40};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] unit = 4'd0, ten = 4'd0, hun = 4'd0;
    logic [3:0] thou = 4'd0, ten_thou = 4'd0, hun_thou = 4'd0;
    logic [2:0] dp_pos = 3'd7;
    logic [5:0] sel;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;
    int n_edges = 0;
    // Per-frame captured display contents: {dp_pos, hun_thou..unit}.
    logic [26:0] frame_snap [int];

    seg_scan_6 #(
        .CNT_MAX     (CNT_MAX),
        .SEG_ACT_LOW (1'b1),
        .SEL_ACT_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .unit     (unit),
        .ten      (ten),
        .hun      (hun),
        .thou     (thou),
        .ten_thou (ten_thou),
        .hun_thou (hun_thou),
`ifdef SEG_DP_EN
        .dp_pos   (dp_pos),
`endif
        .sel      (sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] s_exp, input logic [7:0] g_exp);
        checks++;
        if (sel !== s_exp || seg !== g_exp) begin
            errors++;
            $display("FAIL %s t=%0t edge=%0d sel=%h (want %h) seg=%h (want %h)",
                     name, $time, n_edges, sel, s_exp, seg, g_exp);
        end
    endtask

    // Display after the n-th rising edge since reset release: the first slot
    // stays dark, then slot k shows digit k%6 of frame k/6's snapshot.
    function automatic void expected(input int n, output logic [5:0] es, output logic [7:0] eg);
        int k, d, f, top, dp;
        logic [26:0] s;
        logic [3:0] dig;
        bit show, dpbit;
        es = 6'h3F;
        eg = 8'hFF;
        if (n < CNT_MAX) return;
        k = (n - CNT_MAX) / CNT_MAX;
        d = k % ND;
        f = k / ND;
        s = frame_snap.exists(f) ? frame_snap[f] : 27'h0;
        top = -1;
        for (int i = 0; i < ND; i++) if (s[4*i +: 4] != 4'd0) top = i;
        dig  = s[4*d +: 4];
        dp   = int'(s[26:24]);
        show = (d == 0) || (d <= top);
        dpbit = 1'b0;
`ifdef SEG_DP_EN
        if (dp < ND && d <= dp) show = 1'b1;
        dpbit = (dp == d);
`endif
        es = ~(6'b1 << d);
        eg = ~{dpbit, (show ? PAT[dig] : 7'h00)};
    endfunction

    always @(posedge clk) begin
        logic [5:0] es;
        logic [7:0] eg;
        if (!rst_n) begin
            n_edges = 0;
            frame_snap.delete();
            frame_snap[0] = 27'h0;
            #1 check("reset_model", 6'h3F, 8'hFF);
        end else begin
            n_edges++;
            if (n_edges % FRAME == 0)
                frame_snap[n_edges / FRAME] = {dp_pos, hun_thou, ten_thou, thou, hun, ten, unit};
            #1;
            expected(n_edges, es, eg);
            check("model", es, eg);
        end
    end

    task automatic at_edge(input int target);
        int budget = 3000;
        while (n_edges != target && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (n_edges != target) begin
            checks++;
            errors++;
            $display("FAIL wait_edge edge=%0d (want %0d)", n_edges, target);
        end
    endtask

    task automatic set_digits(input logic [3:0] d5, d4, d3, d2, d1, d0);
        @(negedge clk);
        hun_thou = d5; ten_thou = d4; thou = d3; hun = d2; ten = d1; unit = d0;
    endtask

    task automatic random_inputs(input int cycles);
        int lead;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                lead = $urandom_range(0, ND);
                hun_thou = (lead > 5 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                ten_thou = (lead > 4 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                thou     = (lead > 3 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                hun      = (lead > 2 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                ten      = (lead > 1 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                unit     = 4'($urandom_range(0, 15));
                dp_pos   = 3'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold", 6'h3F, 8'hFF);
        rst_n = 1'b1;

        at_edge(3);   check("first_slot_dark", 6'h3F, 8'hFF);
        at_edge(4);   check("first_slot_zero", 6'h3E, 8'hC0);

        set_digits(4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
        at_edge(32);  check("digit1_two", 6'h3D, 8'hA4);
        at_edge(35);  check("slot_length", 6'h3D, 8'hA4);
        at_edge(36);  check("digit2_three", 6'h3B, 8'hB0);
        at_edge(48);  check("digit5_six", 6'h1F, 8'h82);

        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
        at_edge(76);  check("unit_seven", 6'h3E, 8'hF8);
        at_edge(80);  check("blank_digit1", 6'h3D, 8'hFF);
        at_edge(96);  check("blank_digit5", 6'h1F, 8'hFF);

        set_digits(4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd7);
        at_edge(128); check("inner_zero", 6'h3D, 8'hC0);
        // Change inputs mid-frame; the current frame must not see them.
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd9);
        at_edge(132); check("held_digit2", 6'h3B, 8'hB0);
        at_edge(136); check("held_blank3", 6'h37, 8'hFF);
        at_edge(148); check("new_frame_nine", 6'h3E, 8'h90);
        at_edge(152); check("new_frame_eight", 6'h3D, 8'h80);

        random_inputs(800);

        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hC);
        w = ((n_edges / FRAME) + 1) * FRAME;
        at_edge(w + 4);
        check("dash", 6'h3E, 8'hBF);
        at_edge(w + 5);
        #1 rst_n = 1'b0;
        #1 check("async_reset", 6'h3F, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_edge(3);   check("restart_dark", 6'h3F, 8'hFF);
        at_edge(4);   check("restart_slot0", 6'h3E, 8'hC0);

        random_inputs(200);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout edge=%0d", n_edges);
        $fatal(1, "timeout");
    end

endmodule
